// File: rtl/move_input_if.sv
// Move-command bus between the button conditioner and the game core.
// Carries the raw buttons in and the debounced levels and handshaked move out.
interface move_input_if;
    logic [3:0] buttons;
    logic       move_ready;
    logic       move_valid;
    logic [1:0] move_dir;
    logic [3:0] pressed;
    logic       multi_press;

    modport master (
        output buttons,
        output move_ready,
        input  move_valid,
        input  move_dir,
        input  pressed,
        input  multi_press
    );

    modport slave (
        input  buttons,
        input  move_ready,
        output move_valid,
        output move_dir,
        output pressed,
        output multi_press
    );
endinterface

// File: rtl/move_input.sv
// Synchronises and debounces four active-low buttons, then issues one
// valid/ready move command per clean single-button press.
module move_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic         clk,
    input  logic         rst,
    move_input_if.slave  bus
);

    localparam int unsigned N_BTN = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PEND     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] pressed_q;

    state_t     state_q;
    state_t     state_d;
    logic       valid_q;
    logic       valid_d;
    logic [1:0] dir_q;
    logic [1:0] dir_d;
    logic       multi_q;
    logic       multi_d;
    logic [2:0] n_pressed;
    logic [1:0] first_idx;

    // Two-flop synchroniser; reset value reads as released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= bus.buttons;
            sync2 <= sync1;
        end
    end

    // Per-button debounce; held is active-high, so raw==held means the levels disagree
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [CNT_W-1:0] cnt;
        logic             held;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt  <= '0;
                held <= 1'b0;
            end else if (sync2[i] == held) begin
                if (cnt == CNT_MAX) begin
                    held <= ~held;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end

        assign pressed_q[i] = held;
    end

    // Count held buttons; with a single one held, first_idx is its index
    always_comb begin
        n_pressed = '0;
        first_idx = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (pressed_q[i]) begin
                n_pressed = n_pressed + 3'd1;
                first_idx = 2'(i);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            dir_q   <= 2'b00;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dir_q   <= dir_d;
            multi_q <= multi_d;
        end
    end

    // Next state; IDLE is only entered with everything released, so any press there is new
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (n_pressed == 3'd1) begin
                    state_d = PEND;
                end else if (n_pressed > 3'd1) begin
                    state_d = WAIT_REL;
                end
            end
            PEND: begin
                if (bus.move_ready) begin
                    state_d = (|pressed_q) ? WAIT_REL : IDLE;
                end
            end
            WAIT_REL: begin
                if (!(|pressed_q)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        valid_d = (state_d == PEND);
        dir_d   = dir_q;
        multi_d = 1'b0;
        if (state_q == IDLE && n_pressed == 3'd1) begin
            dir_d = first_idx;
        end
        if (state_q == IDLE && n_pressed > 3'd1) begin
            multi_d = 1'b1;
        end
    end

    assign bus.move_valid  = valid_q;
    assign bus.move_dir    = dir_q;
    assign bus.pressed     = pressed_q;
    assign bus.multi_press = multi_q;

endmodule

// File: tb/tb_move_input.sv
// Self-checking bench for move_input: directed vectors, hand sequences for
// latency/backpressure/reset corners, and random stimulus against a window model.
module tb_move_input;

    localparam int unsigned D  = 4;
    localparam int unsigned CW = 4;

    logic clk;
    logic rst;

    move_input_if bus();

    move_input #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks;
    int         failures;
    int         moves;
    int         multis;
    logic [1:0] last_dir;

    // Reference model state
    logic [3:0] hist [$];
    logic [3:0] m_pressed;
    logic       m_valid;
    logic [1:0] m_dir;
    logic       m_multi;
    int         m_mode;   // 0 waiting for a press, 1 move offered, 2 waiting for release

    typedef struct {
        logic [3:0] btn;
        int         hold;
        logic [3:0] exp_pressed;
        int         exp_moves;
        logic [1:0] exp_dir;
        int         exp_multi;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_out();
        return {bus.move_valid, bus.move_dir, bus.pressed, bus.multi_press};
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < int'(D) + 2; k++) hist.push_back(4'hF);
        m_pressed = 4'b0000;
        m_valid   = 1'b0;
        m_dir     = 2'b00;
        m_multi   = 1'b0;
        m_mode    = 0;
    endtask

    // Advance the model across one clock edge with inputs b / r.
    // A debounced level flips once the D most recent synchronised samples
    // (raw samples delayed by two edges) all disagree with it.
    task automatic model_step(input logic [3:0] b, input logic r);
        logic [3:0] old;
        logic       agree;
        int         n;
        old     = m_pressed;
        m_multi = 1'b0;
        n       = $countones(old);
        case (m_mode)
            0: begin
                if (n == 1) begin
                    m_mode = 1;
                    for (int i = 0; i < 4; i++) if (old[i]) m_dir = 2'(i);
                end else if (n > 1) begin
                    m_mode  = 2;
                    m_multi = 1'b1;
                end
            end
            1: if (r) m_mode = (old != 4'b0000) ? 2 : 0;
            default: if (old == 4'b0000) m_mode = 0;
        endcase
        m_valid = (m_mode == 1);
        hist.push_back(b);
        for (int i = 0; i < 4; i++) begin
            agree = 1'b1;
            for (int j = 0; j < int'(D); j++) begin
                if (hist[hist.size() - 3 - j][i] != old[i]) agree = 1'b0;
            end
            if (agree) m_pressed[i] = ~old[i];
        end
        void'(hist.pop_front());
    endtask

    // One clock: drive, note transfers, step model, compare on the falling edge
    task automatic cyc(input logic [3:0] b, input logic r);
        bus.buttons    = b;
        bus.move_ready = r;
        if (bus.move_valid && r) begin
            moves++;
            last_dir = bus.move_dir;
        end
        if (bus.multi_press) multis++;
        model_step(b, r);
        @(negedge clk);
        chk("model", 32'(dut_out()), 32'({m_valid, m_dir, m_pressed, m_multi}));
    endtask

    // Called at a falling edge; asserts reset mid-cycle and checks the async clear
    task automatic apply_reset(input logic [3:0] b);
        bus.buttons    = b;
        bus.move_ready = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("reset_async", 32'(dut_out()), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic latency_run(input string name, input logic [3:0] b);
        for (int n = 1; n <= 10; n++) begin
            cyc(b, 1'b1);
            chk(name, 32'(bus.move_valid), 32'(n == int'(D) + 3));
        end
    endtask

    initial begin
        logic [3:0] b;
        logic       seen;
        int         hold;
        int         sel;

        checks   = 0;
        failures = 0;
        moves    = 0;
        multis   = 0;
        last_dir = 2'b00;
        rst      = 1'b0;
        bus.buttons    = 4'hF;
        bus.move_ready = 1'b0;
        model_reset();

        vecs[0] = '{4'b1110, 100, 4'b0001, 1, 2'b00, 0};
        vecs[1] = '{4'b0111, 20,  4'b1000, 1, 2'b11, 0};
        vecs[2] = '{4'b0101, 20,  4'b1010, 0, 2'b00, 1};
        vecs[3] = '{4'b1011, 20,  4'b0100, 1, 2'b10, 0};
        vecs[4] = '{4'b1011, 3,   4'b0000, 0, 2'b00, 0};
        vecs[5] = '{4'b1101, 4,   4'b0000, 1, 2'b01, 0};
        vecs[6] = '{4'b0000, 20,  4'b1111, 0, 2'b00, 1};
        vecs[7] = '{4'b1101, 15,  4'b0010, 1, 2'b01, 0};

        @(negedge clk);
        apply_reset(4'hF);

        // Clean press: valid for exactly one cycle, D+3 edges after first sample
        moves = 0;
        latency_run("latency_right", 4'b1110);
        repeat (100) cyc(4'b1110, 1'b1);
        chk("held_moves", 32'(moves), 32'd1);
        chk("held_dir", 32'(last_dir), 32'd0);
        repeat (20) cyc(4'hF, 1'b1);

        // Directed vectors
        for (int v = 0; v < 8; v++) begin
            moves  = 0;
            multis = 0;
            repeat (vecs[v].hold) cyc(vecs[v].btn, 1'b1);
            chk($sformatf("vec%0d_pressed", v), 32'(bus.pressed), 32'(vecs[v].exp_pressed));
            repeat (20) cyc(4'hF, 1'b1);
            chk($sformatf("vec%0d_moves", v), 32'(moves), 32'(vecs[v].exp_moves));
            chk($sformatf("vec%0d_multi", v), 32'(multis), 32'(vecs[v].exp_multi));
            if (vecs[v].exp_moves > 0)
                chk($sformatf("vec%0d_dir", v), 32'(last_dir), 32'(vecs[v].exp_dir));
        end

        // Bounce on the down button every two cycles
        moves = 0;
        seen  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc(((k / 2) % 2 == 0) ? 4'b1011 : 4'hF, 1'b1);
            if (bus.pressed[2]) seen = 1'b1;
        end
        repeat (20) cyc(4'hF, 1'b1);
        chk("bounce_pressed", 32'(seen), 32'd0);
        chk("bounce_moves", 32'(moves), 32'd0);

        // Backpressure: move survives release while ready is low
        moves = 0;
        repeat (10) cyc(4'b1101, 1'b0);
        chk("bp_valid_held", 32'({bus.move_valid, bus.move_dir}), 32'({1'b1, 2'b01}));
        repeat (10) cyc(4'hF, 1'b0);
        chk("bp_after_release", 32'({bus.move_valid, bus.move_dir}), 32'({1'b1, 2'b01}));
        repeat (10) cyc(4'hF, 1'b1);
        chk("bp_moves", 32'(moves), 32'd1);
        chk("bp_dir", 32'(last_dir), 32'd1);
        chk("bp_idle", 32'(bus.move_valid), 32'd0);

        // Reset while a move is pending
        moves = 0;
        repeat (12) cyc(4'b1101, 1'b0);
        chk("pend_before_rst", 32'(bus.move_valid), 32'd1);
        apply_reset(4'hF);
        repeat (20) cyc(4'hF, 1'b1);
        chk("no_replay", 32'(moves), 32'd0);

        // Button held through reset is seen as a new press
        apply_reset(4'b1110);
        latency_run("latency_held_rst", 4'b1110);
        repeat (20) cyc(4'hF, 1'b1);

        // Random stimulus against the model
        for (int t = 0; t < 300; t++) begin
            sel = $urandom_range(0, 5);
            if (sel < 3)       b = 4'hF ^ (4'b0001 << $urandom_range(0, 3));
            else if (sel == 3) b = 4'hF;
            else               b = 4'($urandom);
            hold = $urandom_range(1, 12);
            for (int h = 0; h < hold; h++) cyc(b, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/move_input.md
# move_input

Button-conditioning stage that sits directly upstream of the 2048 game core. It takes the four raw active-low push buttons, synchronises and debounces each one, and turns one clean press into exactly one move command. The command is offered on a valid/ready handshake, so the game FSM consumes each move once, however long the button is held.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles needed to accept a level change (10 ms at 50 MHz). Legal range is 2 to 2^CNT_W−1.
- `CNT_W`, default 20: width of each debounce counter.

Ports:
- `clk` in, 1: single system clock.
- `rst` in, 1: reset, asynchronous, active-high.
- `buttons` in, [3:0]: raw active-low buttons. [3] left, [2] down, [1] up, [0] right.
- `move_ready` in, 1: game core can accept a move.
- `move_valid` out, 1: a move is pending.
- `move_dir` out, [1:0]: direction of the pending move. 00 right, 01 up, 10 down, 11 left (equals the button index).
- `pressed` out, [3:0]: debounced levels, active-high (1 = held).
- `multi_press` out, 1: one-cycle pulse when a move is rejected because more than one button was newly down.

## Operation

Per-button input path:
- Two-flop synchroniser on each button.
- Each button has its own `CNT_W`-bit counter.
- While the synchronised level differs from the debounced level, the counter increments.
- Any cycle where the two levels match clears the counter, so bounce restarts the count.
- When the counter reaches `DEBOUNCE_CYCLES`−1 and the levels still differ, the debounced level toggles and the counter clears.

Control FSM:
- IDLE: all debounced buttons released, `move_valid`=0.
  - Exactly one debounced press rises and all others are released: latch `move_dir` = that index, go to PEND.
  - Two or more debounced presses rise in the same cycle: pulse `multi_press`, go to WAIT_REL.
- PEND: `move_valid`=1 and `move_dir` is held stable.
  - On a cycle with `move_valid`&`move_ready`, the transfer completes.
  - After the transfer, go to WAIT_REL if any button is held, else go to IDLE.
  - Releasing or pressing buttons while in PEND neither cancels nor alters the pending move.
- WAIT_REL: `move_valid`=0. New presses are ignored. When all debounced buttons are released, go to IDLE.

Other rules:
- A second button pressed while the first is held generates no move (WAIT_REL/PEND ignore it).
- `pressed` is the inverted debounced level. It is independent of FSM state.

## Timing

Reset values:
- Synchronisers and debounced levels read as released (raw 1).
- Counters are 0 and the FSM is in IDLE.
- `move_valid`=0, `move_dir`=00, `pressed`=0000, `multi_press`=0.

Latency:
- A raw edge held clean reaches the debounced level at clock edge 2+`DEBOUNCE_CYCLES` after the first sampling edge.
- `move_valid` rises one edge after that, i.e. `DEBOUNCE_CYCLES`+3 edges after sampling.
- With `move_ready`=1 already high, `move_valid` is high for exactly 1 cycle.
- With `move_ready` low, `move_valid` stays high until the first cycle `move_ready`=1, then falls on the next edge.
- `move_ready` is sampled only in PEND. It may be held high permanently.

Boundary cases:
- Bounce shorter than `DEBOUNCE_CYCLES`: no level change and no move.
- Reset asserted mid-PEND: `move_valid` drops immediately (asynchronous), the FSM returns to IDLE, and no move is replayed after reset.
- Button held through reset release: it is debounced as a new press and produces one move after `DEBOUNCE_CYCLES`+3 edges.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4.

- Reset check: assert `rst` asynchronously -> all outputs reset to the values above within the same cycle.
- Clean press: hold `buttons`=4'b1110 (right), `move_ready`=1 -> `move_valid`=1 with `move_dir`=00 for exactly 1 cycle, 7 edges after the first sampling edge. Hold the button 100 cycles -> no further moves. Release and press left (4'b0111) -> exactly one move with `move_dir`=11.
- Bounce rejection: toggle bit 2 every 2 cycles for 20 cycles, then release -> `move_valid` stays 0 and `pressed`[2] stays 0.
- Backpressure: press up with `move_ready`=0 for 10 cycles, release the button during the wait -> `move_valid` held, `move_dir`=01. Raise `move_ready` -> exactly one transfer, then IDLE.
- Simultaneous press: drive `buttons`=4'b0101 on the same edge -> `multi_press` pulses once and no `move_valid`. After full release, press down -> one move with `move_dir`=10.
- Reset mid-PEND: `move_ready`=0, move pending, pulse `rst` -> `move_valid`=0 immediately and no move after release, provided the buttons were released during reset.
